appr_mult_arb: RTL

Shares one `appr_mult` approximate 8x8 multiplier among `NUM_REQ` systolic-cell requesters. It grants at most one operand pair per cycle and registers the operands into the multiplier. It tracks each in-flight product with a tag pipeline matching the multiplier latency. Each result is returned to its owner through a one-entry response buffer per requester with valid/ready backpressure.

---
 rtl/appr_mult_arb.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/appr_mult_arb.sv
// appr_mult_arb: shares one approximate 8x8 multiplier among NUM_REQ requesters.
// Define APPR_MULT_ARB_RR_EN for round-robin arbitration; otherwise lowest eligible index wins.
module appr_mult_arb #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned MUL_LAT = 1
) (
  input  logic                   iClk,
  input  logic                   iRst,
  input  logic [NUM_REQ-1:0]     iReqValid,
  input  logic [8*NUM_REQ-1:0]   iReqData1,
  input  logic [8*NUM_REQ-1:0]   iReqData2,
  output logic [NUM_REQ-1:0]     oReqReady,
  output logic [7:0]             oMulData1,
  output logic [7:0]             oMulData2,
  output logic                   oMulValid,
  input  logic [19:0]            iMulResult,
  output logic [NUM_REQ-1:0]     oRspValid,
  output logic [20*NUM_REQ-1:0]  oRspData,
  input  logic [NUM_REQ-1:0]     iRspReady,
  output logic                   oBusy
);

  localparam int unsigned TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned OP_W  = 8;
  localparam int unsigned RES_W = 20;

  logic [NUM_REQ-1:0] pending_q, pending_d;
  logic [NUM_REQ-1:0] rsp_vld_q, rsp_vld_d;
  logic [RES_W-1:0]   rsp_data_q [NUM_REQ];
  logic [RES_W-1:0]   rsp_data_d [NUM_REQ];
  logic [OP_W-1:0]    mul_data1_q, mul_data1_d;
  logic [OP_W-1:0]    mul_data2_q, mul_data2_d;
  logic               mul_vld_q, mul_vld_d;
  logic [TAG_W-1:0]   mul_idx_q, mul_idx_d;
  logic               tag_vld_q [MUL_LAT];
  logic               tag_vld_d [MUL_LAT];
  logic [TAG_W-1:0]   tag_idx_q [MUL_LAT];
  logic [TAG_W-1:0]   tag_idx_d [MUL_LAT];

  logic [NUM_REQ-1:0] eligible_c;
  logic [NUM_REQ-1:0] rsp_hs_c;
  logic               hi_hit_c, lo_hit_c, gnt_any_c;
  logic [TAG_W-1:0]   hi_idx_c, lo_idx_c, gnt_idx_c;

`ifdef APPR_MULT_ARB_RR_EN
  logic [TAG_W-1:0]   ptr_q, ptr_d;
`endif

  assign eligible_c = iReqValid & ~pending_q;
  assign rsp_hs_c   = rsp_vld_q & iRspReady;

  // Grant search: indices above ptr first (round-robin), else lowest eligible index.
  always_comb begin
    hi_hit_c = 1'b0;
    hi_idx_c = '0;
    lo_hit_c = 1'b0;
    lo_idx_c = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (eligible_c[i]) begin
`ifdef APPR_MULT_ARB_RR_EN
        if (TAG_W'(i) > ptr_q) begin
          hi_hit_c = 1'b1;
          hi_idx_c = TAG_W'(i);
        end else begin
          lo_hit_c = 1'b1;
          lo_idx_c = TAG_W'(i);
        end
`else
        lo_hit_c = 1'b1;
        lo_idx_c = TAG_W'(i);
`endif
      end
    end
    gnt_any_c = hi_hit_c | lo_hit_c;
    gnt_idx_c = hi_hit_c ? hi_idx_c : lo_idx_c;
  end

  always_comb begin
    oReqReady = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (gnt_any_c && (gnt_idx_c == TAG_W'(i))) oReqReady[i] = 1'b1;
    end
  end

  // Issue stage, tag pipeline and response buffers.
  always_comb begin
    mul_vld_d   = gnt_any_c;
    mul_idx_d   = gnt_any_c ? gnt_idx_c : mul_idx_q;
    mul_data1_d = mul_data1_q;
    mul_data2_d = mul_data2_q;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (gnt_any_c && (gnt_idx_c == TAG_W'(i))) begin
        mul_data1_d = iReqData1[OP_W*i +: OP_W];
        mul_data2_d = iReqData2[OP_W*i +: OP_W];
      end
    end
`ifdef APPR_MULT_ARB_RR_EN
    ptr_d = gnt_any_c ? gnt_idx_c : ptr_q;
`endif
    tag_vld_d[0] = mul_vld_q;
    tag_idx_d[0] = mul_idx_q;
    for (int s = 1; s < int'(MUL_LAT); s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_idx_d[s] = tag_idx_q[s-1];
    end
    pending_d = (pending_q | (oReqReady & iReqValid)) & ~rsp_hs_c;
    rsp_vld_d = rsp_vld_q & ~rsp_hs_c;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      rsp_data_d[i] = rsp_data_q[i];
      if (tag_vld_q[MUL_LAT-1] && (tag_idx_q[MUL_LAT-1] == TAG_W'(i))) begin
        rsp_vld_d[i]  = 1'b1;
        rsp_data_d[i] = iMulResult;
      end
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      pending_q   <= '0;
      rsp_vld_q   <= '0;
      mul_data1_q <= '0;
      mul_data2_q <= '0;
      mul_vld_q   <= 1'b0;
      mul_idx_q   <= '0;
`ifdef APPR_MULT_ARB_RR_EN
      ptr_q       <= TAG_W'(NUM_REQ - 1);
`endif
      for (int i = 0; i < int'(NUM_REQ); i++) rsp_data_q[i] <= '0;
      for (int s = 0; s < int'(MUL_LAT); s++) begin
        tag_vld_q[s] <= 1'b0;
        tag_idx_q[s] <= '0;
      end
    end else begin
      pending_q   <= pending_d;
      rsp_vld_q   <= rsp_vld_d;
      mul_data1_q <= mul_data1_d;
      mul_data2_q <= mul_data2_d;
      mul_vld_q   <= mul_vld_d;
      mul_idx_q   <= mul_idx_d;
`ifdef APPR_MULT_ARB_RR_EN
      ptr_q       <= ptr_d;
`endif
      for (int i = 0; i < int'(NUM_REQ); i++) rsp_data_q[i] <= rsp_data_d[i];
      for (int s = 0; s < int'(MUL_LAT); s++) begin
        tag_vld_q[s] <= tag_vld_d[s];
        tag_idx_q[s] <= tag_idx_d[s];
      end
    end
  end

  always_comb begin
    oRspData = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) oRspData[RES_W*i +: RES_W] = rsp_data_q[i];
  end

  assign oMulData1 = mul_data1_q;
  assign oMulData2 = mul_data2_q;
  assign oMulValid = mul_vld_q;
  assign oRspValid = rsp_vld_q;
  assign oBusy     = |pending_q;

endmodule
